// File: rtl/pulse_writeback_sequencer_if.sv
// Write-address handshake: the sequencer drives valid/addr, the writeback path returns ready.
interface pulse_writeback_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;

    modport master (output wr_valid, output wr_addr, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, output wr_ready);
endinterface

// File: rtl/pulse_writeback_sequencer.sv
// Counts slow_pulse events and issues one raster-ordered write address each; PWS_DROP_COUNT_EN adds drop_cnt.
// Latency: a pulse sampled at an edge raises wr_valid right after that edge (registered-state decode).
// Backpressure: address held while wr_ready is low; excess pulses saturate the pending counter and set overflow.
module pulse_writeback_sequencer #(
    parameter int CNT_W  = 8,
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int ADDR_W = 16
) (
    input  logic                slow_clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic                slow_pulse,
    pulse_writeback_sequencer_if.master wr,
    output logic                busy,
    output logic                frame_done,
    output logic                overflow
`ifdef PWS_DROP_COUNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0]    ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  pending, pending_nxt;
    logic [RW-1:0]     row, row_nxt;
    logic [CW-1:0]     col, col_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic              overflow_nxt;
    logic              hs;
    logic              last;
    logic              pulse_lost;

    assign wr.wr_valid = (state == RUN) && (pending != '0);
    assign wr.wr_addr  = addr;
    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);
    assign hs          = wr.wr_valid && wr.wr_ready;
    assign last        = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            row      <= '0;
            col      <= '0;
            addr     <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            addr     <= addr_nxt;
            overflow <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        row_nxt      = row;
        col_nxt      = col;
        addr_nxt     = addr;
        overflow_nxt = overflow;
        pulse_lost   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = RUN;
                    addr_nxt     = cfg_base;
                    row_nxt      = '0;
                    col_nxt      = '0;
                    pending_nxt  = '0;
                    overflow_nxt = 1'b0;
                end
            end
            RUN: begin
                if (hs) begin
                    addr_nxt = addr + 1'b1;
                    if (col == COL_LAST) begin
                        col_nxt = '0;
                        row_nxt = row + 1'b1;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
                if (hs && last) begin
                    // Frame complete: anything still pending belongs to no element.
                    state_nxt   = DONE;
                    pending_nxt = '0;
                    row_nxt     = '0;
                    col_nxt     = '0;
                end else if (slow_pulse && !hs) begin
                    if (pending == PEND_MAX) begin
                        overflow_nxt = 1'b1;
                        pulse_lost   = 1'b1;
                    end else begin
                        pending_nxt = pending + 1'b1;
                    end
                end else if (!slow_pulse && hs) begin
                    pending_nxt = pending - 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PWS_DROP_COUNT_EN
    logic [CNT_W:0] residual;
    logic [16:0]    drop_inc;
    logic [16:0]    drop_sum;

    always_comb begin
        residual = {1'b0, pending} + {{CNT_W{1'b0}}, slow_pulse} - {{CNT_W{1'b0}}, 1'b1};
        drop_inc = '0;
        if (((state == IDLE) && !start) || (state == DONE)) begin
            drop_inc = {16'd0, slow_pulse};
        end else if (state == RUN) begin
            if (hs && last)
                drop_inc = 17'(residual);
            else if (pulse_lost)
                drop_inc = 17'd1;
        end
        drop_sum = {1'b0, drop_cnt} + drop_inc;
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if ((state == IDLE) && start)
            drop_cnt <= '0;
        else if (drop_sum[16])
            drop_cnt <= 16'hFFFF;
        else
            drop_cnt <= drop_sum[15:0];
    end
`endif
endmodule
